// File: rtl/gcd_up_pkg.sv
// Shared definitions for the gcd_up accumulator machine: widths, opcodes, FSM states,
// control-word bit positions and the fixed GCD program image.
package gcd_up_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 5;
    localparam int CTRL_W   = 11;
    localparam int MEM_SIZE = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_INPUT = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_WAIT_IN = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam int CS_IR_LD    = 10;
    localparam int CS_PC_LD    = 9;
    localparam int CS_JMP_SEL  = 8;
    localparam int CS_ADDR_SEL = 7;
    localparam int CS_MEM_WE   = 6;
    localparam int CS_A_SEL    = 4;
    localparam int CS_A_LD     = 3;
    localparam int CS_ALU_OP   = 1;
    localparam int CS_OUT_LD   = 0;

    localparam logic [1:0] ASEL_INPUT = 2'b00;
    localparam logic [1:0] ASEL_RAM   = 2'b01;
    localparam logic [1:0] ASEL_ALU   = 2'b10;
    localparam logic [1:0] ASEL_HOLD  = 2'b11;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Subtractive Euclid: x in RAM[30], y in RAM[31]; result left in RAM[30].
    localparam logic [DATA_W-1:0] ROM_INIT [MEM_SIZE] = '{
        8'h80, 8'h3E, 8'h80, 8'h3F, 8'h1E, 8'h7F, 8'hAE, 8'hCC,
        8'h1F, 8'h7E, 8'h3F, 8'hC4, 8'h3E, 8'hC4, 8'h1E, 8'hE0,
        8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0,
        8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'hE0
    };

endpackage

// File: rtl/gcd_up_ctrl.sv
// Sequencer for gcd_up: fetch/decode/execute FSM with input wait and halt states,
// decoding the current state, opcode and accumulator flags into the control word.
module gcd_up_ctrl
    import gcd_up_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              init,
    input  op_t               op,
    input  logic              a_zero,
    input  logic              a_pos,
    input  logic              enter_edge,
    output logic [CTRL_W-1:0] ctrl,
    output logic              halt
);

    state_t state;

    always_ff @(posedge CLOCK) begin
        if (!RESET || init) begin
            state <= S_FETCH;
            halt  <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_INPUT) begin
                        state <= S_WAIT_IN;
                    end else if (op == OP_HALT) begin
                        state <= S_HALT;
                        halt  <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC:    state <= S_FETCH;
                S_WAIT_IN: if (enter_edge) state <= S_FETCH;
                S_HALT:    state <= S_HALT;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // The operand address is selected from DECODE onward so RAM data is stable in EXEC.
    always_comb begin
        ctrl = '0;
        ctrl[CS_A_SEL +: 2]  = ASEL_HOLD;
        ctrl[CS_ALU_OP +: 2] = ALU_PASS;
        case (state)
            S_FETCH: begin
                ctrl[CS_IR_LD] = 1'b1;
                ctrl[CS_PC_LD] = 1'b1;
            end
            S_DECODE: begin
                ctrl[CS_ADDR_SEL] = 1'b1;
                if (op == OP_HALT) ctrl[CS_OUT_LD] = 1'b1;
            end
            S_EXEC: begin
                ctrl[CS_ADDR_SEL] = 1'b1;
                case (op)
                    OP_LOAD: begin
                        ctrl[CS_A_SEL +: 2] = ASEL_RAM;
                        ctrl[CS_A_LD]       = 1'b1;
                    end
                    OP_STORE: ctrl[CS_MEM_WE] = 1'b1;
                    OP_ADD: begin
                        ctrl[CS_A_SEL +: 2]  = ASEL_ALU;
                        ctrl[CS_ALU_OP +: 2] = ALU_ADD;
                        ctrl[CS_A_LD]        = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl[CS_A_SEL +: 2]  = ASEL_ALU;
                        ctrl[CS_ALU_OP +: 2] = ALU_SUB;
                        ctrl[CS_A_LD]        = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl[CS_PC_LD]   = a_zero;
                        ctrl[CS_JMP_SEL] = a_zero;
                    end
                    OP_JPOS: begin
                        ctrl[CS_PC_LD]   = a_pos;
                        ctrl[CS_JMP_SEL] = a_pos;
                    end
                    default: ;
                endcase
            end
            S_WAIT_IN: begin
                if (enter_edge) begin
                    ctrl[CS_A_SEL +: 2] = ASEL_INPUT;
                    ctrl[CS_A_LD]       = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gcd_up.sv
// Multicycle 8-bit accumulator CPU running a fixed GCD program (PC, IR, A, ROM, RAM, ALU).
// Define UP_DEBUG_EN to expose the live control word and opcode on CtrlSignals/Ins.
module gcd_up
    import gcd_up_pkg::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Enter,
    input  logic              Init,
    input  logic [DATA_W-1:0] Input,
    output logic              Halt,
    output logic [DATA_W-1:0] Output,
    output logic [CTRL_W-1:0] CtrlSignals,
    output logic [2:0]        Ins
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] out_r;
    logic              enter_q;
    logic [DATA_W-1:0] ram [MEM_SIZE];

    logic [CTRL_W-1:0] cw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
    logic [DATA_W-1:0] alu;
    logic              a_zero;
    logic              a_pos;
    logic              enter_edge;
    logic              clear;

    assign clear      = !RESET || Init;
    assign enter_edge = Enter && !enter_q;
    assign a_zero     = (a == '0);
    assign a_pos      = !a[DATA_W-1] && !a_zero;
    assign addr       = cw[CS_ADDR_SEL] ? ir[ADDR_W-1:0] : pc;
    assign mdata      = ram[addr];

    gcd_up_ctrl u_ctrl (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .init       (Init),
        .op         (op_t'(ir[DATA_W-1 -: 3])),
        .a_zero     (a_zero),
        .a_pos      (a_pos),
        .enter_edge (enter_edge),
        .ctrl       (cw),
        .halt       (Halt)
    );

    always_comb begin
        case (cw[CS_ALU_OP +: 2])
            ALU_ADD: alu = a + mdata;
            ALU_SUB: alu = a - mdata;
            default: alu = mdata;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (clear) begin
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            out_r   <= '0;
            enter_q <= 1'b0;
        end else begin
            enter_q <= Enter;
            if (cw[CS_IR_LD]) ir <= ROM_INIT[pc];
            if (cw[CS_PC_LD]) pc <= cw[CS_JMP_SEL] ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
            if (cw[CS_A_LD]) begin
                case (cw[CS_A_SEL +: 2])
                    ASEL_INPUT: a <= Input;
                    ASEL_RAM:   a <= mdata;
                    ASEL_ALU:   a <= alu;
                    default:    a <= a;
                endcase
            end
            if (cw[CS_OUT_LD]) out_r <= a;
        end
    end

    // RAM survives RESET; only Init (with RESET released) wipes it.
    always_ff @(posedge CLOCK) begin
        if (RESET && Init) begin
            for (int unsigned i = 0; i < MEM_SIZE; i++) ram[i] <= '0;
        end else if (RESET && cw[CS_MEM_WE]) begin
            ram[addr] <= a;
        end
    end

    assign Output = out_r;

`ifdef UP_DEBUG_EN
    assign CtrlSignals = cw;
    assign Ins         = ir[DATA_W-1 -: 3];
`else
    assign CtrlSignals = '0;
    assign Ins         = '0;
`endif

endmodule

// File: tb/tb_gcd_up.sv
// Self-checking bench for gcd_up: directed and random operand pairs against a modulo-Euclid model.
`timescale 1ns/1ps
module tb_gcd_up;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        Enter = 1'b0;
    logic        Init  = 1'b0;
    logic [7:0]  Input = 8'd0;
    logic        Halt;
    logic [7:0]  Output;
    logic [10:0] CtrlSignals;
    logic [2:0]  Ins;

    int checks = 0;
    int errors = 0;

    gcd_up dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .Enter       (Enter),
        .Init        (Init),
        .Input       (Input),
        .Halt        (Halt),
        .Output      (Output),
        .CtrlSignals (CtrlSignals),
        .Ins         (Ins)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic int ref_gcd(int x, int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic cycles(int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    task automatic pulse(logic [7:0] v, int len);
        Input = v;
        Enter = 1'b1;
        cycles(len);
        Enter = 1'b0;
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (Halt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK);
        end
    endtask

    task automatic run_pair(logic [7:0] x, logic [7:0] y, int lenx, int leny, output bit ok);
        cycles(4);
        pulse(x, lenx);
        cycles(8);
        pulse(y, leny);
        wait_halt(ok);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (Halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_halt got %b expected 0", Halt);
        end
        checks++;
        if (Output !== 8'd0) begin
            errors++;
            $display("FAIL reset_output got %0d expected 0", Output);
        end
`ifdef UP_DEBUG_EN
        checks++;
        if (CtrlSignals[10:9] !== 2'b11) begin
            errors++;
            $display("FAIL fetch_ctrl got %b expected 11", CtrlSignals[10:9]);
        end
`else
        checks++;
        if (CtrlSignals !== 11'd0 || Ins !== 3'd0) begin
            errors++;
            $display("FAIL debug_off got %b/%b expected 0/0", CtrlSignals, Ins);
        end
`endif
    endtask

    task automatic test_directed();
        int xs [4] = '{12, 17, 99, 127};
        int ys [4] = '{18, 5, 99, 1};
        bit ok;
        int exp;
        for (int i = 0; i < 4; i++) begin
            exp = ref_gcd(xs[i], ys[i]);
            do_reset();
            run_pair(8'(xs[i]), 8'(ys[i]), 1, 1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL directed_halt %0d,%0d got Halt=%b expected 1", xs[i], ys[i], Halt);
            end
            checks++;
            if (Output !== 8'(exp)) begin
                errors++;
                $display("FAIL directed_out %0d,%0d got %0d expected %0d", xs[i], ys[i], Output, exp);
            end
`ifdef UP_DEBUG_EN
            checks++;
            if (Ins !== 3'b111) begin
                errors++;
                $display("FAIL halt_ins got %b expected 111", Ins);
            end
`endif
        end
    endtask

    task automatic test_held_enter();
        bit ok;
        int x, y;
        do_reset();
        run_pair(8'd35, 8'd21, 2, 2, ok);
        checks++;
        if (!ok || Output !== 8'(ref_gcd(35, 21))) begin
            errors++;
            $display("FAIL held2 got halt=%b out=%0d expected 1/%0d", Halt, Output, ref_gcd(35, 21));
        end
        // A long first pulse must not also feed the second INPUT.
        x = $urandom_range(2, 127);
        y = $urandom_range(1, x - 1);
        do_reset();
        run_pair(8'(x), 8'(y), 8, 1, ok);
        checks++;
        if (!ok || Output !== 8'(ref_gcd(x, y))) begin
            errors++;
            $display("FAIL held8 %0d,%0d got halt=%b out=%0d expected 1/%0d", x, y, Halt, Output, ref_gcd(x, y));
        end
    endtask

    task automatic test_halt_reset();
        bit ok;
        int prev;
        prev = ref_gcd(35, 21);
        do_reset();
        run_pair(8'd35, 8'd21, 1, 1, ok);
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        checks++;
        if (Halt !== 1'b0 || Output !== 8'd0) begin
            errors++;
            $display("FAIL halt_reset got halt=%b out=%0d expected 0/0", Halt, Output);
        end
        checks++;
        if (dut.ram[30] !== 8'(prev) || dut.ram[31] !== 8'(prev)) begin
            errors++;
            $display("FAIL ram_kept got %0d,%0d expected %0d,%0d", dut.ram[30], dut.ram[31], prev, prev);
        end
        run_pair(8'd48, 8'd36, 1, 1, ok);
        checks++;
        if (!ok || Output !== 8'(ref_gcd(48, 36))) begin
            errors++;
            $display("FAIL rerun got halt=%b out=%0d expected 1/%0d", Halt, Output, ref_gcd(48, 36));
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int x, y;
        do_reset();
        cycles(4);
        pulse(8'd127, 1);
        cycles(8);
        pulse(8'd1, 1);
        cycles(300);
        checks++;
        if (Halt !== 1'b0) begin
            errors++;
            $display("FAIL midrun_busy got %b expected 0", Halt);
        end
        do_reset();
        cycles(40);
        checks++;
        if (Halt !== 1'b0 || Output !== 8'd0) begin
            errors++;
            $display("FAIL midrun_wait got halt=%b out=%0d expected 0/0", Halt, Output);
        end
        x = $urandom_range(1, 127);
        y = $urandom_range(1, 127);
        run_pair(8'(x), 8'(y), 1, 1, ok);
        checks++;
        if (!ok || Output !== 8'(ref_gcd(x, y))) begin
            errors++;
            $display("FAIL midrun_restart %0d,%0d got halt=%b out=%0d expected 1/%0d", x, y, Halt, Output, ref_gcd(x, y));
        end
    endtask

    task automatic test_init();
        bit ok;
        int x, y;
        @(negedge CLOCK);
        Init = 1'b1;
        @(negedge CLOCK);
        Init = 1'b0;
        checks++;
        if (dut.ram[30] !== 8'd0 || dut.ram[31] !== 8'd0) begin
            errors++;
            $display("FAIL init_ram got %0d,%0d expected 0,0", dut.ram[30], dut.ram[31]);
        end
        checks++;
        if (Halt !== 1'b0 || Output !== 8'd0) begin
            errors++;
            $display("FAIL init_regs got halt=%b out=%0d expected 0/0", Halt, Output);
        end
        x = $urandom_range(1, 127);
        y = $urandom_range(1, 127);
        run_pair(8'(x), 8'(y), 1, 1, ok);
        checks++;
        if (!ok || Output !== 8'(ref_gcd(x, y))) begin
            errors++;
            $display("FAIL init_run %0d,%0d got halt=%b out=%0d expected 1/%0d", x, y, Halt, Output, ref_gcd(x, y));
        end
    endtask

    task automatic test_random();
        bit ok;
        int x, y;
        for (int i = 0; i < 8; i++) begin
            x = $urandom_range(1, 127);
            y = $urandom_range(1, 127);
            do_reset();
            run_pair(8'(x), 8'(y), 1, 1, ok);
            checks++;
            if (!ok || Output !== 8'(ref_gcd(x, y))) begin
                errors++;
                $display("FAIL random %0d,%0d got halt=%b out=%0d expected 1/%0d", x, y, Halt, Output, ref_gcd(x, y));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_held_enter();
        test_halt_reset();
        test_mid_reset();
        test_init();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
